mc_control_fsm: RTL and testbench

Multi-cycle main control sequencer for the RV32I core. Decodes the opcode of the instruction register and steps the shared datapath (single memory port, single ALU, PC, IR, register file) through fetch/decode/execute/memory/writeback. Drives `alu_op` into the ALU control decoder, which turns it plus funct3/funct7 into the 4-bit ALU control line. Also counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/mc_control_fsm.sv | 160 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module : riscv_ctrl_pkg
// Brief  : Shared state, opcode and datapath-select encodings for the RV32I
//          multi-cycle control sequencer and the ALU control decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module : mc_control_fsm
// Brief  : Multi-cycle RV32I main control sequencer with retired-instruction
//          counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic                  mem_ready,
  input  logic                  zero,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic [1:0]            result_src,
  output logic                  illegal,
  output logic [data_width-1:0] instr_retired
);

  state_e                state_q, state_d;
  logic [data_width-1:0] instr_retired_q, instr_retired_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      instr_retired_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ITYPE:     state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase

    // An instruction retires on the edge that returns the sequencer to FETCH;
    // ILLEGAL never leaves, so it can never retire.
    instr_retired_d = instr_retired_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      instr_retired_d = instr_retired_q + {{(data_width-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    result_src    = RES_ALU_OUT;
    illegal       = 1'b0;
    instr_retired = '0;
    if (!reset) begin
      instr_retired = instr_retired_q;
      unique case (state_q)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          pc_write   = mem_ready;
          ir_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_OP_SUB;
          pc_write  = zero;
        end
        // Jump target already sits in ALUOut from DECODE; the ALU computes
        // old PC + 4 here so ALUWB can write the link address to rd.
        S_JAL: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_ILLEGAL: begin
          illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module : tb_mc_control_fsm
// Brief  : Scoreboard bench for mc_control_fsm with a 4-bit retire counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'b0110011;
  logic          mem_ready = 1'b0;
  logic          zero = 1'b0;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_write, illegal;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic [DW-1:0] instr_retired;

  mc_control_fsm #(.data_width(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .illegal      (illegal),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, illegal,
  //  alu_src_a, alu_src_b, alu_op, result_src}
  localparam logic [14:0] E_RESET    = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] E_FETCH_W  = {7'b0001000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [14:0] E_FETCH_R  = {7'b1101000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [14:0] E_DECODE   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] E_MEMADR   = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] E_MEMREAD  = {7'b0011000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] E_MEMWB    = {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [14:0] E_MEMWRITE = {7'b0010100, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] E_EXEC_R   = {7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [14:0] E_EXEC_I   = {7'b0000000, 2'b10, 2'b01, 2'b10, 2'b00};
  localparam logic [14:0] E_ALUWB    = {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] E_BEQ_T    = {7'b1000000, 2'b10, 2'b00, 2'b01, 2'b00};
  localparam logic [14:0] E_BEQ_N    = {7'b0000000, 2'b10, 2'b00, 2'b01, 2'b00};
  localparam logic [14:0] E_JAL      = {7'b1000000, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [14:0] E_ILLEGAL  = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00};

  typedef struct {
    logic [14:0]   ctl;
    logic [DW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] cnt = '0;

  wire [14:0] act_ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                         illegal, alu_src_a, alu_src_b, alu_op, result_src};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act_ctl !== e.ctl) begin
        n_bad++;
        $display("FAIL %s ctl: got %b want %b @%0t", e.tag, act_ctl, e.ctl, $time);
      end
      n_cmp++;
      if (instr_retired !== e.cnt) begin
        n_bad++;
        $display("FAIL %s count: got %0d want %0d @%0t", e.tag, instr_retired, e.cnt, $time);
      end
    end
  end

  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [14:0] ctl, input string tag);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    sb.push_back('{ctl: ctl, cnt: (rst ? '0 : cnt), tag: tag});
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(0, 0, 0, E_FETCH_W, "fetch_wait");
    cyc(0, 1, 0, E_FETCH_R, "fetch");
    cyc(0, 1, 0, E_DECODE, "decode");
  endtask

  task automatic do_reset(input string tag);
    cnt = '0;
    cyc(1, 1, 0, E_RESET, tag);
  endtask

  task automatic rtype;
    opcode = 7'b0110011;
    fetch(0);
    cyc(0, 1, 0, E_EXEC_R, "exec_r");
    cyc(0, 1, 0, E_ALUWB, "aluwb_r");
    cnt = cnt + 1'b1;
  endtask

  initial begin
    // Reset held two cycles, then a zero-wait R-type.
    do_reset("reset0");
    do_reset("reset1");
    rtype();

    // lw: one fetch wait, three MEMREAD waits.
    opcode = 7'b0000011;
    fetch(1);
    cyc(0, 1, 0, E_MEMADR, "memadr_lw");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, E_MEMREAD, "memread_wait");
    cyc(0, 1, 0, E_MEMREAD, "memread");
    cyc(0, 0, 0, E_MEMWB, "memwb");
    cnt = cnt + 1'b1;

    // sw with one wait cycle.
    opcode = 7'b0100011;
    fetch(0);
    cyc(0, 1, 0, E_MEMADR, "memadr_sw");
    cyc(0, 0, 0, E_MEMWRITE, "memwrite_wait");
    cyc(0, 1, 0, E_MEMWRITE, "memwrite");
    cnt = cnt + 1'b1;

    // I-type ALU.
    opcode = 7'b0010011;
    fetch(0);
    cyc(0, 1, 0, E_EXEC_I, "exec_i");
    cyc(0, 1, 0, E_ALUWB, "aluwb_i");
    cnt = cnt + 1'b1;

    // beq taken then not taken.
    opcode = 7'b1100011;
    fetch(0);
    cyc(0, 1, 1, E_BEQ_T, "beq_taken");
    cnt = cnt + 1'b1;
    fetch(0);
    cyc(0, 1, 0, E_BEQ_N, "beq_not_taken");
    cnt = cnt + 1'b1;

    // jal.
    opcode = 7'b1101111;
    fetch(0);
    cyc(0, 1, 0, E_JAL, "jal");
    cyc(0, 1, 0, E_ALUWB, "aluwb_jal");
    cnt = cnt + 1'b1;

    // Reset arriving with mem_ready during a MEMWRITE wait.
    opcode = 7'b0100011;
    fetch(0);
    cyc(0, 1, 0, E_MEMADR, "memadr_sw2");
    cyc(0, 0, 0, E_MEMWRITE, "memwrite_wait2");
    do_reset("reset_in_memwrite");
    // Reset coinciding with mem_ready in FETCH: no pc/ir write.
    cyc(0, 0, 0, E_FETCH_W, "fetch_after_reset");
    do_reset("reset_in_fetch");

    // 16 R-types wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) rtype();
    cyc(0, 0, 0, E_FETCH_W, "fetch_after_wrap");

    // Illegal opcode: sticky, frozen count, cleared by reset.
    opcode = 7'b1111111;
    cyc(0, 1, 0, E_FETCH_R, "fetch_ill");
    cyc(0, 1, 0, E_DECODE, "decode_ill");
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, E_ILLEGAL, "illegal_hold");
    do_reset("reset_ill");
    rtype();
    cyc(0, 0, 0, E_FETCH_W, "fetch_final");

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
